rca32_operand_sequencer: RTL and testbench

- Sits directly upstream of the 32-bit ripple-carry adder netlist and feeds its add1/add2 operand inputs.
- Accepts tagged operand pairs over a valid/ready interface and buffers them in a FIFO.
- Drives one pair at a time onto the adder, waits a fixed settle time, then captures the adder's 33-bit result.
- Compares the captured result against an internal golden sum, for locked/obfuscated netlist evaluation, and returns result, tag and mismatch flag over a valid/ready output.

---
 rtl/rca32_operand_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rca32_operand_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca32_operand_sequencer.sv
// Feeds operand pairs from a small FIFO into the 32-bit ripple-carry adder netlist,
// lets them settle, captures the 33-bit result and flags any difference from the true sum.
module rca32_operand_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [31:0]      add1_o,
    output logic [31:0]      add2_o,
    input  logic [32:0]      result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_sum_o,
    output logic             res_cout_o,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             res_mismatch_o,
    output logic [15:0]      err_cnt_o,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    logic [31:0]      a_mem   [DEPTH];
    logic [31:0]      b_mem   [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [31:0]      add1_q, add1_d;
    logic [31:0]      add2_q, add2_d;
    logic [32:0]      golden_q, golden_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             res_valid_q, res_valid_d;
    logic [32:0]      res_q, res_d;
    logic             res_mm_q, res_mm_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic push;
    logic pop;
    logic capture;
    logic fifo_empty;
    logic is_mismatch;

    assign fifo_empty  = (count_q == '0);
    assign in_ready_o  = (count_q != FULL_CNT);
    assign push        = in_valid_i && in_ready_o;
    assign is_mismatch = (result_i != golden_q);

    // Operand storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            a_mem[wr_ptr_q]   <= in_a_i;
            b_mem[wr_ptr_q]   <= in_b_i;
            tag_mem[wr_ptr_q] <= in_tag_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        settle_d    = settle_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    capture     = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // Releasing a result and loading the next pair share one edge.
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            settle_d = SETTLE_INIT;
        end
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        add1_d    = add1_q;
        add2_d    = add2_q;
        golden_d  = golden_q;
        tag_d     = tag_q;
        if (pop) begin
            add1_d   = a_mem[rd_ptr_q];
            add2_d   = b_mem[rd_ptr_q];
            golden_d = {1'b0, a_mem[rd_ptr_q]} + {1'b0, b_mem[rd_ptr_q]};
            tag_d    = tag_mem[rd_ptr_q];
        end
        res_d     = capture ? result_i : res_q;
        res_mm_d  = capture ? is_mismatch : res_mm_q;
        err_cnt_d = err_cnt_q;
        if (capture && is_mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            settle_q    <= '0;
            add1_q      <= '0;
            add2_q      <= '0;
            golden_q    <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_mm_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            settle_q    <= settle_d;
            add1_q      <= add1_d;
            add2_q      <= add2_d;
            golden_q    <= golden_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            res_mm_q    <= res_mm_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign add1_o         = add1_q;
    assign add2_o         = add2_q;
    assign res_valid_o    = res_valid_q;
    assign res_sum_o      = res_q[31:0];
    assign res_cout_o     = res_q[32];
    assign res_tag_o      = tag_q;
    assign res_mismatch_o = res_mm_q;
    assign err_cnt_o      = err_cnt_q;
    assign busy_o         = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_rca32_operand_sequencer.sv
// Directed bench: one sequencer with SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3, each driving a behavioural adder.
module tb_rca32_operand_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic [31:0] add1, add2;
    logic [32:0] result;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_sum;
    logic        res_cout, res_mm, busy;
    logic [3:0]  res_tag;
    logic [15:0] err_cnt;
    logic        fault = 1'b0;

    assign result = ({1'b0, add1} + {1'b0, add2}) ^ (fault ? 33'h1 : 33'h0);

    logic        in_valid3 = 1'b0, in_ready3;
    logic [31:0] in_a3 = '0, in_b3 = '0;
    logic [3:0]  in_tag3 = '0;
    logic [31:0] add1_3, add2_3;
    logic [32:0] result3;
    logic        res_valid3, res_ready3 = 1'b0;
    logic [31:0] res_sum3;
    logic        res_cout3, res_mm3, busy3;
    logic [3:0]  res_tag3;
    logic [15:0] err_cnt3;

    assign result3 = {1'b0, add1_3} + {1'b0, add2_3};

    rca32_operand_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
        .add1_o(add1), .add2_o(add2), .result_i(result),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_sum_o(res_sum), .res_cout_o(res_cout), .res_tag_o(res_tag),
        .res_mismatch_o(res_mm), .err_cnt_o(err_cnt), .busy_o(busy)
    );

    rca32_operand_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3), .TAG_W(4)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .in_a_i(in_a3), .in_b_i(in_b3), .in_tag_i(in_tag3),
        .add1_o(add1_3), .add2_o(add2_3), .result_i(result3),
        .res_valid_o(res_valid3), .res_ready_i(res_ready3),
        .res_sum_o(res_sum3), .res_cout_o(res_cout3), .res_tag_o(res_tag3),
        .res_mismatch_o(res_mm3), .err_cnt_o(err_cnt3), .busy_o(busy3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; drops in_valid after the edge that accepted it.
    task automatic tick();
        logic pushed;
        pushed = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (pushed) in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        in_a = a;
        in_b = b;
        in_tag = t;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && in_valid; i++) tick();
        if (in_valid) begin
            chk("push_timeout", in_valid, 1'b0);
            in_valid = 1'b0;
        end
    endtask

    task automatic get_result(input string name, input logic [32:0] exp, input logic [3:0] t,
                              input logic mm);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        chk({name, "_valid"}, res_valid, 1'b1);
        chk({name, "_sum"}, res_sum, exp[31:0]);
        chk({name, "_cout"}, res_cout, exp[32]);
        chk({name, "_tag"}, res_tag, t);
        chk({name, "_mm"}, res_mm, mm);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_add1", add1, 32'h0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_sum", res_sum, 32'h0);

        // Basic operation and latency.
        push(32'h5, 32'h3, 4'h2);
        chk("basic_busy", busy, 1'b1);
        tick();
        chk("basic_add1", add1, 32'h5);
        chk("basic_add2", add2, 32'h3);
        chk("basic_not_yet", res_valid, 1'b0);
        tick();
        chk("basic_valid", res_valid, 1'b1);
        chk("basic_sum", res_sum, 32'h8);
        chk("basic_cout", res_cout, 1'b0);
        chk("basic_tag", res_tag, 4'h2);
        chk("basic_mm", res_mm, 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("basic_cleared", res_valid, 1'b0);
        chk("basic_idle", busy, 1'b0);

        // Carry out of bit 31.
        push(32'hFFFF_FFFF, 32'h0000_0001, 4'h3);
        get_result("carry1", 33'h1_0000_0000, 4'h3, 1'b0);
        push(32'h8000_0000, 32'h8000_0000, 4'h4);
        get_result("carry2", 33'h1_0000_0000, 4'h4, 1'b0);

        // Backpressure until the FIFO fills.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 32'h1000_0000 + 32'(i);
            bp_b[i] = 32'h0000_0100 * 32'(i + 1);
        end
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], 4'(i));
        chk("bp_full", in_ready, 1'b0);
        in_a = bp_a[5];
        in_b = bp_b[5];
        in_tag = 4'd5;
        in_valid = 1'b1;
        tick();
        tick();
        chk("bp_stalled", in_valid, 1'b1);
        chk("bp_hold_valid", res_valid, 1'b1);
        chk("bp_hold_tag", res_tag, 4'd0);
        chk("bp_hold_add1", add1, bp_a[0]);
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 50 && !res_valid; i++) tick();
            chk("bp_valid", res_valid, 1'b1);
            chk("bp_tag", res_tag, 4'(k));
            chk("bp_sum", {res_cout, res_sum}, {1'b0, bp_a[k]} + {1'b0, bp_b[k]});
            tick();
        end
        res_ready = 1'b0;
        chk("bp_sixth_taken", in_valid, 1'b0);
        chk("bp_drained", busy, 1'b0);

        // Corrupt only the second of three results.
        chk("fi_err_before", err_cnt, 16'd0);
        push(32'd10, 32'd20, 4'd6);
        get_result("fi_op1", 33'd30, 4'd6, 1'b0);
        fault = 1'b1;
        push(32'd100, 32'd200, 4'd7);
        get_result("fi_op2", 33'd301, 4'd7, 1'b1);
        fault = 1'b0;
        push(32'd1000, 32'd2000, 4'd8);
        get_result("fi_op3", 33'd3000, 4'd8, 1'b0);
        chk("fi_err_cnt", err_cnt, 16'd1);

        // Asynchronous reset while a pair settles and two more are queued.
        push(32'd1, 32'd1, 4'd9);
        push(32'd2, 32'd2, 4'd10);
        push(32'd3, 32'd3, 4'd11);
        push(32'd4, 32'd4, 4'd12);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ar_loaded", add1, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", res_valid, 1'b0);
        chk("ar_add1", add1, 32'h0);
        chk("ar_add2", add2, 32'h0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_busy", busy, 1'b0);
        chk("ar_err_cnt", err_cnt, 16'h0);
        chk("ar_tag", res_tag, 4'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("ar_no_stale", res_valid, 1'b0);
        chk("ar_still_idle", busy, 1'b0);
        push(32'd7, 32'd9, 4'd13);
        get_result("ar_after", 33'd16, 4'd13, 1'b0);

        // Throughput with SETTLE_CYCLES=3 and the consumer always ready.
        begin
            int          last_v;
            int          npulse;
            int          nchg;
            logic        pv;
            logic        pushed3;
            logic [31:0] prev_add1;
            last_v = -1;
            npulse = 0;
            nchg = 0;
            pv = 1'b0;
            prev_add1 = add1_3;
            res_ready3 = 1'b1;
            in_a3 = 32'd1;
            in_b3 = 32'h100;
            in_valid3 = 1'b1;
            for (int c = 0; c < 40; c++) begin
                pushed3 = in_valid3 && in_ready3;
                @(posedge clk);
                #1;
                if (pushed3) begin
                    in_a3 = in_a3 + 32'd1;
                    in_tag3 = in_tag3 + 4'd1;
                end
                if (res_valid3) begin
                    if (last_v >= 0) chk("tp_period", 64'(c - last_v), 64'd4);
                    last_v = c;
                    npulse++;
                    chk("tp_mm", res_mm3, 1'b0);
                end
                if (add1_3 != prev_add1) begin
                    if (nchg > 0) chk("tp_load_edge", pv, 1'b1);
                    nchg++;
                    prev_add1 = add1_3;
                end
                pv = res_valid3;
            end
            chk("tp_pulses", 64'(npulse), 64'd9);
            in_valid3 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
